store_commit_buffer: RTL and testbench

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

---
 rtl/store_commit_buffer_pkg.sv | 21 ++
 rtl/store_commit_buffer_if.sv | 33 +++
 rtl/sb_fifo.sv | 63 ++++++
 rtl/store_commit_buffer.sv | 123 ++++++++++++
 tb/tb_store_commit_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_commit_buffer_pkg.sv
// Shared types and constants for the store commit buffer.
//   sb_entry_s        : one buffered store {addr, data}
//   sb_state_e        : write-request FSM states
//   SB_DEPTH_DEFAULT  : default number of buffered stores
package store_commit_buffer_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;
  localparam int unsigned SB_AW            = 32;
  localparam int unsigned SB_DW            = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_s;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_e;

endpackage

// File: rtl/store_commit_buffer_if.sv
// Bus bundle between the commit stage / data memory / load unit and the
// store commit buffer.
//   master : drives commit_*, mem_ack, ld_addr; observes status and memory request
//   slave  : the buffer itself
interface store_commit_buffer_if;
  import store_commit_buffer_pkg::*;

  logic             commit_valid;
  logic             commit_store;
  logic [SB_AW-1:0] commit_dst;
  logic [SB_DW-1:0] commit_value;
  logic             sb_full;
  logic             sb_empty;
  logic             sb_overflow;
  logic             mem_req;
  logic [SB_AW-1:0] mem_addr;
  logic [SB_DW-1:0] mem_wdata;
  logic             mem_ack;
  logic [SB_AW-1:0] ld_addr;
  logic             ld_hit;
  logic [SB_DW-1:0] ld_data;

  modport master (
    output commit_valid, commit_store, commit_dst, commit_value, mem_ack, ld_addr,
    input  sb_full, sb_empty, sb_overflow, mem_req, mem_addr, mem_wdata, ld_hit, ld_data
  );

  modport slave (
    input  commit_valid, commit_store, commit_dst, commit_value, mem_ack, ld_addr,
    output sb_full, sb_empty, sb_overflow, mem_req, mem_addr, mem_wdata, ld_hit, ld_data
  );

endinterface

// File: rtl/sb_fifo.sv
// Circular storage for committed stores with head/tail/count bookkeeping.
//   clk_i, reset_i : clock, async active-high reset (clears pointers/count)
//   push_i         : store wants to enter the buffer
//   push_entry_i   : store payload
//   pop_i          : head entry retired (caller guarantees count > 0)
//   accept_o       : push taken this cycle (room, or full with a pop)
//   head_entry_o   : oldest entry
//   head_o         : head pointer
//   count_o        : number of valid entries
//   entries_o      : raw storage, for forwarding lookup
module sb_fifo
  import store_commit_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = SB_DEPTH_DEFAULT,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  sb_entry_s              push_entry_i,
  input  logic                   pop_i,
  output logic                   accept_o,
  output sb_entry_s              head_entry_o,
  output logic [PW-1:0]          head_o,
  output logic [CW-1:0]          count_o,
  output sb_entry_s [DEPTH-1:0]  entries_o
);

  sb_entry_s [DEPTH-1:0] mem_q;
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;

  // A full buffer still takes a push when the head retires on the same edge.
  assign accept_o = push_i && ((count_q < CW'(DEPTH)) || pop_i);
  assign count_d  = count_q + CW'(accept_o) - CW'(pop_i);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept_o) tail_q <= tail_q + PW'(1);
      if (pop_i)    head_q <= head_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Payload storage; validity is tracked by head/count only.
  always_ff @(posedge clk_i) begin
    if (accept_o) mem_q[tail_q] <= push_entry_i;
  end

  assign head_entry_o = mem_q[head_q];
  assign head_o       = head_q;
  assign count_o      = count_q;
  assign entries_o    = mem_q;

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds committed stores and drains them to data memory
// one at a time, with optional store-to-load forwarding.
//   clk_i   : clock
//   reset_i : async active-high reset; abandons any in-flight write
//   bus     : slave side of store_commit_buffer_if
//             commit_*  -> push a committed store
//             mem_*     -> registered write request to memory, head entry
//             ld_*      -> forwarding lookup (youngest matching entry)
//             sb_full / sb_empty / sb_overflow (sticky) status
// Build option: define SB_FWD_EN to include forwarding; otherwise ld_hit and
// ld_data are tied to 0 and ld_addr is ignored.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  store_commit_buffer_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_state_e             state_q;
  logic                  mem_req_q;
  logic                  overflow_q;

  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  last_pop;
  sb_entry_s             push_entry;
  sb_entry_s             head_entry;
  logic [PW-1:0]         head;
  logic [CW-1:0]         count;
  sb_entry_s [DEPTH-1:0] entries;

  assign push       = bus.commit_valid && bus.commit_store;
  // Acks are only meaningful while a request is outstanding.
  assign pop        = bus.mem_ack && (state_q == SB_REQ);
  assign push_entry = '{addr: bus.commit_dst, data: bus.commit_value};
  // Buffer goes empty on this edge: the acked entry was the only one and no
  // replacement arrives.
  assign last_pop   = pop && (count == CW'(1)) && !accept;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .accept_o     (accept),
    .head_entry_o (head_entry),
    .head_o       (head),
    .count_o      (count),
    .entries_o    (entries)
  );

  // Write-request FSM; mem_req is registered alongside the state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= SB_IDLE;
      mem_req_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push && !accept) overflow_q <= 1'b1;
      case (state_q)
        SB_IDLE: begin
          if (count != '0) begin
            state_q   <= SB_REQ;
            mem_req_q <= 1'b1;
          end
        end
        SB_REQ: begin
          if (last_pop) begin
            state_q   <= SB_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= SB_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Address/data are the head entry, which only moves on an accepted ack,
  // so they stay stable for the whole request. Gated to 0 when idle.
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_req_q ? head_entry.addr : '0;
  assign bus.mem_wdata   = mem_req_q ? head_entry.data : '0;
  assign bus.sb_full     = (count == CW'(DEPTH));
  assign bus.sb_empty    = (count == '0);
  assign bus.sb_overflow = overflow_q;

`ifdef SB_FWD_EN
  logic             fwd_hit;
  logic [SB_DW-1:0] fwd_data;

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (entries[head + PW'(i)].addr == bus.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[head + PW'(i)].data;
      end
    end
  end

  assign bus.ld_hit  = fwd_hit;
  assign bus.ld_data = fwd_data;
`else
  logic unused_fwd;
  assign unused_fwd  = ^{bus.ld_addr, entries, head};
  assign bus.ld_hit  = 1'b0;
  assign bus.ld_data = '0;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: a directed vector table,
// hand-written corner sequences, and randomized traffic against a queue model.
module tb_store_commit_buffer;
  import store_commit_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NL    = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  store_commit_buffer_if sb_if ();

  store_commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (sb_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  // ---------------- reference model: FIFO queue + request flag ----------------
  sb_entry_s mq[$];
  bit        m_req;
  bit        m_ovf;

  function automatic void model_reset();
    mq.delete();
    m_req = 1'b0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_edge();
    bit pop, push, acc;
    int old;
    old  = mq.size();
    pop  = sb_if.mem_ack && m_req;
    push = sb_if.commit_valid && sb_if.commit_store;
    acc  = push && ((old < int'(DEPTH)) || pop);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back('{addr: sb_if.commit_dst, data: sb_if.commit_value});
    else if (push) m_ovf = 1'b1;
    if (!m_req) m_req = (old > 0);
    else if (pop && mq.size() == 0) m_req = 1'b0;
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] ea, ed, eld;
    logic        eh;
    ea = 0; ed = 0; eh = 0; eld = 0;
    if (m_req && mq.size() > 0) begin
      ea = mq[0].addr;
      ed = mq[0].data;
    end
`ifdef SB_FWD_EN
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == sb_if.ld_addr) begin
        eh  = 1'b1;
        eld = mq[i].data;
        break;
      end
    end
`endif
    chk1({tag, " mem_req"}, sb_if.mem_req, m_req);
    chk ({tag, " mem_addr"}, sb_if.mem_addr, ea);
    chk ({tag, " mem_wdata"}, sb_if.mem_wdata, ed);
    chk1({tag, " sb_full"}, sb_if.sb_full, mq.size() == int'(DEPTH));
    chk1({tag, " sb_empty"}, sb_if.sb_empty, mq.size() == 0);
    chk1({tag, " sb_overflow"}, sb_if.sb_overflow, m_ovf);
    chk1({tag, " ld_hit"}, sb_if.ld_hit, eh);
    chk ({tag, " ld_data"}, sb_if.ld_data, eld);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit cv, input bit cs, input logic [31:0] dst,
                       input logic [31:0] val, input bit ack, input logic [31:0] ld);
    sb_if.commit_valid = cv;
    sb_if.commit_store = cs;
    sb_if.commit_dst   = dst;
    sb_if.commit_value = val;
    sb_if.mem_ack      = ack;
    sb_if.ld_addr      = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_model(tag);
    tick();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    model_reset();
    #1;
    chk1("rst mem_req", sb_if.mem_req, 1'b0);
    chk ("rst mem_addr", sb_if.mem_addr, 32'h0);
    chk ("rst mem_wdata", sb_if.mem_wdata, 32'h0);
    chk1("rst sb_full", sb_if.sb_full, 1'b0);
    chk1("rst sb_empty", sb_if.sb_empty, 1'b1);
    chk1("rst sb_overflow", sb_if.sb_overflow, 1'b0);
    chk1("rst ld_hit", sb_if.ld_hit, 1'b0);
    chk ("rst ld_data", sb_if.ld_data, 32'h0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    drive(0, 0, 0, 0, 0, NL);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          cv, cs;
    logic [31:0] dst, val;
    bit          ack;
    logic [31:0] ld;
    bit          e_req;
    logic [31:0] e_addr, e_data;
    bit          e_full, e_empty, e_ovf, e_hit;
    logic [31:0] e_ld;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(bit cv, bit cs, logic [31:0] dst, logic [31:0] val, bit ack,
                              logic [31:0] ld, bit er, logic [31:0] ea, logic [31:0] ed,
                              bit ef, bit ee, bit eo, bit eh, logic [31:0] el);
    vec_t v;
    v.cv = cv; v.cs = cs; v.dst = dst; v.val = val; v.ack = ack; v.ld = ld;
    v.e_req = er; v.e_addr = ea; v.e_data = ed;
    v.e_full = ef; v.e_empty = ee; v.e_ovf = eo; v.e_hit = eh; v.e_ld = el;
    return v;
  endfunction

  // Wrap-around capture
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  initial begin
    drive(0, 0, 0, 0, 0, NL);
    do_reset();

    // Single store then fill/overflow/drain; values are pre-edge outputs.
    tbl[0]  = mk(1,1,32'h100, 32'hDEADBEEF,0,NL,      0,32'h0,   32'h0,       0,1,0,0,32'h0);
    tbl[1]  = mk(1,0,32'h555, 32'h66,      0,32'h100, 0,32'h0,   32'h0,       0,0,0,1,32'hDEADBEEF);
    tbl[2]  = mk(0,0,32'h0,   32'h0,       0,NL,      1,32'h100, 32'hDEADBEEF,0,0,0,0,32'h0);
    tbl[3]  = mk(0,0,32'h0,   32'h0,       0,32'h100, 1,32'h100, 32'hDEADBEEF,0,0,0,1,32'hDEADBEEF);
    tbl[4]  = mk(0,0,32'h0,   32'h0,       1,NL,      1,32'h100, 32'hDEADBEEF,0,0,0,0,32'h0);
    tbl[5]  = mk(1,1,32'h1000,32'h1,       1,NL,      0,32'h0,   32'h0,       0,1,0,0,32'h0);
    tbl[6]  = mk(1,1,32'h1004,32'h2,       0,NL,      0,32'h0,   32'h0,       0,0,0,0,32'h0);
    tbl[7]  = mk(1,1,32'h1008,32'h3,       0,NL,      1,32'h1000,32'h1,       0,0,0,0,32'h0);
    tbl[8]  = mk(1,1,32'h100C,32'h4,       0,NL,      1,32'h1000,32'h1,       0,0,0,0,32'h0);
    tbl[9]  = mk(1,1,32'h1010,32'h5,       0,32'h1010,1,32'h1000,32'h1,       1,0,0,0,32'h0);
    tbl[10] = mk(0,0,32'h0,   32'h0,       0,32'h1008,1,32'h1000,32'h1,       1,0,1,1,32'h3);
    tbl[11] = mk(0,0,32'h0,   32'h0,       1,NL,      1,32'h1000,32'h1,       1,0,1,0,32'h0);
    tbl[12] = mk(0,0,32'h0,   32'h0,       1,NL,      1,32'h1004,32'h2,       0,0,1,0,32'h0);
    tbl[13] = mk(0,0,32'h0,   32'h0,       1,NL,      1,32'h1008,32'h3,       0,0,1,0,32'h0);
    tbl[14] = mk(0,0,32'h0,   32'h0,       1,NL,      1,32'h100C,32'h4,       0,0,1,0,32'h0);
    tbl[15] = mk(0,0,32'h0,   32'h0,       0,NL,      0,32'h0,   32'h0,       0,1,1,0,32'h0);

    for (int i = 0; i < 16; i++) begin
      logic        eh;
      logic [31:0] el;
      string       tag;
      tag = $sformatf("row%0d", i);
      drive(tbl[i].cv, tbl[i].cs, tbl[i].dst, tbl[i].val, tbl[i].ack, tbl[i].ld);
      eh = tbl[i].e_hit;
      el = tbl[i].e_ld;
`ifndef SB_FWD_EN
      eh = 1'b0;
      el = 32'h0;
`endif
      @(negedge clk);
      chk1({tag, " mem_req"}, sb_if.mem_req, tbl[i].e_req);
      chk ({tag, " mem_addr"}, sb_if.mem_addr, tbl[i].e_addr);
      chk ({tag, " mem_wdata"}, sb_if.mem_wdata, tbl[i].e_data);
      chk1({tag, " sb_full"}, sb_if.sb_full, tbl[i].e_full);
      chk1({tag, " sb_empty"}, sb_if.sb_empty, tbl[i].e_empty);
      chk1({tag, " sb_overflow"}, sb_if.sb_overflow, tbl[i].e_ovf);
      chk1({tag, " ld_hit"}, sb_if.ld_hit, eh);
      chk ({tag, " ld_data"}, sb_if.ld_data, el);
      tick();
    end

    // Full buffer plus ack: push accepted, no overflow, count stays at DEPTH.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 32'h2000 + 32'(4 * k), 32'hB0 + 32'(k), 0, NL);
      step("fill");
    end
    drive(1, 1, 32'h2010, 32'hB4, 1, NL);
    @(negedge clk);
    chk1("fullack pre sb_full", sb_if.sb_full, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, NL);
    @(negedge clk);
    chk1("fullack sb_full", sb_if.sb_full, 1'b1);
    chk1("fullack sb_overflow", sb_if.sb_overflow, 1'b0);
    chk ("fullack next head", sb_if.mem_addr, 32'h2004);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 1, NL);
      step("fullack drain");
    end
    drive(0, 0, 0, 0, 0, NL);
    step("fullack idle");

    // Forwarding: two stores to one address, youngest wins.
    do_reset();
    drive(1, 1, 32'h200, 32'h11, 0, NL);
    step("fwd push1");
    drive(1, 1, 32'h200, 32'h22, 0, NL);
    step("fwd push2");
    drive(0, 0, 0, 0, 0, 32'h200);
    @(negedge clk);
`ifdef SB_FWD_EN
    chk1("fwd hit 0x200", sb_if.ld_hit, 1'b1);
    chk ("fwd data 0x200", sb_if.ld_data, 32'h22);
`else
    chk1("fwd hit 0x200", sb_if.ld_hit, 1'b0);
    chk ("fwd data 0x200", sb_if.ld_data, 32'h0);
`endif
    sb_if.ld_addr = 32'h204;
    #1;
    chk1("fwd hit 0x204", sb_if.ld_hit, 1'b0);
    chk ("fwd data 0x204", sb_if.ld_data, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 32'h200);
      step("fwd drain");
    end

    // Reset in the middle of a request; later acks are ignored.
    do_reset();
    drive(1, 1, 32'h300, 32'h33, 0, NL);
    step("rmid push");
    drive(0, 0, 0, 0, 0, NL);
    step("rmid wait");
    @(negedge clk);
    chk1("rmid req before", sb_if.mem_req, 1'b1);
    #2;
    reset_i = 1'b1;
    model_reset();
    #1;
    chk1("rmid req async", sb_if.mem_req, 1'b0);
    chk1("rmid empty async", sb_if.sb_empty, 1'b1);
    chk ("rmid addr async", sb_if.mem_addr, 32'h0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, NL);
      step("rmid late ack");
    end
    drive(0, 0, 0, 0, 0, NL);

    // Wrap-around: ten stores streamed with ack held high.
    do_reset();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    begin
      int k;
      k = 0;
      for (int c = 0; c < 13; c++) begin
        if (c == 0 || (c >= 2 && c <= 10)) begin
          drive(1, 1, 32'h4000 + 32'(4 * k), 32'hA000 + 32'(k), 1, NL);
          k++;
        end else begin
          drive(0, 0, 0, 0, 1, NL);
        end
        @(negedge clk);
        check_model("wrap");
        if (sb_if.mem_req && sb_if.mem_ack) begin
          wr_addr.push_back(sb_if.mem_addr);
          wr_data.push_back(sb_if.mem_wdata);
          wr_cyc.push_back(c);
        end
        tick();
      end
    end
    chk("wrap write count", 32'(wr_addr.size()), 32'd10);
    if (wr_addr.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("wrap addr%0d", k), wr_addr[k], 32'h4000 + 32'(4 * k));
        chk($sformatf("wrap data%0d", k), wr_data[k], 32'hA000 + 32'(k));
      end
      chk("wrap no gaps", 32'(wr_cyc[9] - wr_cyc[0]), 32'd9);
    end
    drive(0, 0, 0, 0, 0, NL);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(99) < 60, $urandom_range(99) < 80,
              32'h500 + 32'(4 * $urandom_range(7)), $urandom,
              $urandom_range(99) < 40, 32'h500 + 32'(4 * $urandom_range(7)));
        step("rand");
      end
    end
    for (int k = 0; k < int'(DEPTH) + 3; k++) begin
      drive(0, 0, 0, 0, 1, NL);
      step("rand drain");
    end
    @(negedge clk);
    chk1("final sb_empty", sb_if.sb_empty, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
